mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous-read byte-write RAM (1-cycle read latency, read-before-write, write-byte-enable) between two requesters, e.g. instruction fetch (port 0) and load/store (port 1).
- Arbitrates round-robin, drives the RAM port, and returns each accepted access's read data to its requester exactly one cycle after acceptance.
- Sits between the CPU or memory-mapped clients and the RAM instance.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 16 +
 rtl/mem_port_arbiter.sv | 56 +++++
 tb/tb_mem_port_arbiter.sv | 129 ++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared port indices and write-detect helper for the memory port arbiter
package mem_arb_pkg;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;
  localparam int MAX_BYTES = 16;
  function automatic logic wbe_is_write(input logic [MAX_BYTES-1:0] wbe);
    return |wbe;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: two requester ports plus the RAM port of the arbiter
interface mem_port_arbiter_if #(parameter int DWIDTH = 32, parameter int AWIDTH = 12);
  logic req0_valid, req0_ready, resp0_valid;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH/8-1:0] req0_wbe;
  logic [DWIDTH-1:0] req0_wdata, resp0_rdata;
  logic req1_valid, req1_ready, resp1_valid;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH/8-1:0] req1_wbe;
  logic [DWIDTH-1:0] req1_wdata, resp1_rdata;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_d, mem_q;
  logic [DWIDTH/8-1:0] mem_wbe;
  logic mem_en;
  modport master (
    output req0_valid, req0_addr, req0_wbe, req0_wdata,
    output req1_valid, req1_addr, req1_wbe, req1_wdata, mem_q,
    input req0_ready, resp0_valid, resp0_rdata,
    input req1_ready, resp1_valid, resp1_rdata,
    input mem_addr, mem_d, mem_wbe, mem_en
  );
  modport slave (
    input req0_valid, req0_addr, req0_wbe, req0_wdata,
    input req1_valid, req1_addr, req1_wbe, req1_wdata, mem_q,
    output req0_ready, resp0_valid, resp0_rdata,
    output req1_ready, resp1_valid, resp1_rdata,
    output mem_addr, mem_d, mem_wbe, mem_en
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker; on a tie the port not granted last wins
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_gnt,
  output logic [1:0] gnt,
  output logic       idx,
  output logic       any
);
  always_comb begin
    any = |valid;
    idx = &valid ? ~last_gnt : valid[PORT_LS];
    gnt = any ? (idx == PORT_LS ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one sync-read byte-write RAM between two requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BYTES = DWIDTH / 8;
  logic last_gnt, resp_pend, resp_sel;
  logic [1:0] gnt;
  logic idx, any, accept;
  logic [AWIDTH-1:0] addr_g;
  logic [DWIDTH-1:0] data_g;
  logic [BYTES-1:0] wbe_g;
  rr_pick2 u_pick (
    .valid({bus.req1_valid, bus.req0_valid}),
    .last_gnt(last_gnt),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  always_comb begin
    accept = any & ~rst;
    addr_g = idx == PORT_LS ? bus.req1_addr : bus.req0_addr;
    data_g = idx == PORT_LS ? bus.req1_wdata : bus.req0_wdata;
    wbe_g = idx == PORT_LS ? bus.req1_wbe : bus.req0_wbe;
    bus.req0_ready = gnt[PORT_IF] & ~rst;
    bus.req1_ready = gnt[PORT_LS] & ~rst;
    bus.mem_en = accept;
    bus.mem_addr = addr_g;
    bus.mem_d = data_g;
    bus.mem_wbe = accept ? wbe_g : '0;
    // RAM output is shared; only the matching valid qualifies it
    bus.resp0_valid = resp_pend & (resp_sel == PORT_IF);
    bus.resp1_valid = resp_pend & (resp_sel == PORT_LS);
    bus.resp0_rdata = bus.mem_q;
    bus.resp1_rdata = bus.mem_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      resp_pend <= 1'b0;
      resp_sel <= 1'b0;
    end else begin
      resp_pend <= accept;
      if (accept) begin
        last_gnt <= idx;
        resp_sel <= idx;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, response pairing, writes and reset
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  int n_tests = 0, n_fail = 0;
  logic [31:0] ram [0:4095];
  logic [31:0] q;
  mem_port_arbiter_if #(.DWIDTH(32), .AWIDTH(12)) bus ();
  mem_port_arbiter #(.DWIDTH(32), .AWIDTH(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.mem_en) begin
      q <= ram[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_wbe[b]) ram[bus.mem_addr][8*b+:8] <= bus.mem_d[8*b+:8];
    end
  assign bus.mem_q = q;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v0, input logic [11:0] a0, input logic v1, input logic [11:0] a1, input logic [3:0] w1, input logic [31:0] d1);
    bus.req0_valid = v0;
    bus.req0_addr = a0;
    bus.req0_wbe = 4'h0;
    bus.req0_wdata = 32'h0;
    bus.req1_valid = v1;
    bus.req1_addr = a1;
    bus.req1_wbe = w1;
    bus.req1_wdata = d1;
  endtask
  task automatic next;
    @(posedge clk);
    #1;
  endtask
  // stimulus table: port 1 alone three times, then a 4-cycle tie, then drain
  logic [1:0] tv [0:7];
  logic [1:0] tg [0:7];
  logic [1:0] prev;
  initial begin
    ram[12'h010] = 32'hDEADBEEF;
    ram[12'h020] = 32'hAABBCCDD;
    ram[12'h001] = 32'h01010101;
    ram[12'h002] = 32'h02020202;
    q = 32'h0;
    tv = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    tg = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    drive(1, 12'h010, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("rst_ready0", {31'b0, bus.req0_ready}, 0);
    check("rst_mem_en", {31'b0, bus.mem_en}, 0);
    next;
    rst = 0;
    @(negedge clk);
    check("t1_ready0", {31'b0, bus.req0_ready}, 1);
    check("t1_ready1", {31'b0, bus.req1_ready}, 0);
    check("t1_addr", {20'b0, bus.mem_addr}, 32'h010);
    check("t1_resp_idle", {30'b0, bus.resp1_valid, bus.resp0_valid}, 0);
    next;
    drive(0, 12'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("t1_resp0_valid", {31'b0, bus.resp0_valid}, 1);
    check("t1_resp1_valid", {31'b0, bus.resp1_valid}, 0);
    check("t1_rdata", bus.resp0_rdata, 32'hDEADBEEF);
    prev = 2'b00;
    for (int i = 0; i < 8; i++) begin
      next;
      drive(tv[i][0], 12'h001, tv[i][1], 12'h002, 4'h0, 32'h0);
      @(negedge clk);
      check($sformatf("rr_gnt%0d", i), {30'b0, bus.req1_ready, bus.req0_ready}, {30'b0, tg[i]});
      check($sformatf("rr_resp%0d", i), {30'b0, bus.resp1_valid, bus.resp0_valid}, {30'b0, prev});
      if (prev != 2'b00)
        check($sformatf("rr_rdata%0d", i), bus.mem_q, prev[0] ? 32'h01010101 : 32'h02020202);
      prev = tg[i];
    end
    next;
    drive(0, 12'h0, 1, 12'h020, 4'b0101, 32'h11223344);
    @(negedge clk);
    check("wr_ready1", {31'b0, bus.req1_ready}, 1);
    check("wr_mem_wbe", {28'b0, bus.mem_wbe}, 32'h5);
    check("wr_mem_d", bus.mem_d, 32'h11223344);
    check("wr_mem_addr", {20'b0, bus.mem_addr}, 32'h020);
    next;
    drive(1, 12'h020, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("wr_resp1_valid", {31'b0, bus.resp1_valid}, 1);
    check("wr_resp1_old", bus.resp1_rdata, 32'hAABBCCDD);
    check("rd_ready0", {31'b0, bus.req0_ready}, 1);
    check("rd_mem_wbe", {28'b0, bus.mem_wbe}, 0);
    next;
    drive(1, 12'h010, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("rd_resp0_valid", {31'b0, bus.resp0_valid}, 1);
    check("rd_resp0_new", bus.resp0_rdata, 32'hAA22CC44);
    check("t5_ready0", {31'b0, bus.req0_ready}, 1);
    next;
    rst = 1;
    drive(1, 12'h010, 1, 12'h002, 4'h3, 32'hFFFFFFFF);
    @(negedge clk);
    check("t5_rst_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 0);
    check("t5_rst_mem_en", {31'b0, bus.mem_en}, 0);
    check("t5_rst_wbe", {28'b0, bus.mem_wbe}, 0);
    next;
    rst = 0;
    drive(1, 12'h010, 1, 12'h002, 4'h0, 32'h0);
    @(negedge clk);
    check("t5_dropped_resp", {30'b0, bus.resp1_valid, bus.resp0_valid}, 0);
    check("t5_tie_port0", {30'b0, bus.req1_ready, bus.req0_ready}, 2'b01);
    next;
    drive(0, 12'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("t6_resp0", {30'b0, bus.resp1_valid, bus.resp0_valid}, 2'b01);
    check("t6_rdata", bus.resp0_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        next;
        @(negedge clk);
        check($sformatf("idle_resp%0d", i), {30'b0, bus.resp1_valid, bus.resp0_valid}, 0);
      end
      check($sformatf("idle_en%0d", i), {31'b0, bus.mem_en}, 0);
      check($sformatf("idle_wbe%0d", i), {28'b0, bus.mem_wbe}, 0);
      check($sformatf("idle_ready%0d", i), {30'b0, bus.req1_ready, bus.req0_ready}, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
